// File: rtl/add64_operand_loader.sv
// add64_operand_loader
//   Sequential front end for the 64-bit adder. Two 64-bit operands arrive as
//   eight 16-bit beats (a low-to-high, then b low-to-high). One ADD cycle
//   computes a+b with carry-in 0. The registered sum and carry-out are then
//   held behind a valid/ready handshake.
//
// Optional feature macro: ADD64_OVF_EN
//   When defined, adds the out_ovf port and its register: signed overflow of
//   a+b. It is cleared by reset only.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous abort (partial operands, held result)
//   in_valid/in_ready beat handshake, in_data = 16-bit beat
//   out_valid/out_ready result handshake
//   out_sum, out_cout registered a+b and carry-out of bit 63
//   out_ovf           signed overflow (ADD64_OVF_EN only)
module add64_operand_loader #(
    parameter int BEAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_sum,
    output logic              out_cout
`ifdef ADD64_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int NUM_BEATS = 128 / BEAT_W;   // 8 beats: 4 for a, 4 for b

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ADD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [2:0] cnt;

    // Beat store; beats[3:0] is a and beats[7:4] is b, with the lowest beat
    // in the least significant position, so each half reads directly as a
    // packed 64-bit operand.
    logic [NUM_BEATS-1:0][BEAT_W-1:0] beats;
    logic [63:0] op_a, op_b;
    logic [64:0] sum_w;
    logic        beat_take;

    assign op_a  = beats[NUM_BEATS/2-1:0];
    assign op_b  = beats[NUM_BEATS-1:NUM_BEATS/2];
    assign sum_w = {1'b0, op_a} + {1'b0, op_b};

    // Handshake outputs are decoded from registered state only.
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_HOLD);

    // clr outranks the beat transfer in the same cycle.
    assign beat_take = in_ready && in_valid && !clr;

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (in_valid && cnt == 3'd7) state_nxt = S_ADD;
            S_ADD:  state_nxt = S_HOLD;
            S_HOLD: if (out_ready) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
        if (clr) state_nxt = S_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat counter and operand store. The counter wraps 7->0 on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 3'd0;
            beats <= '0;
        end else if (clr) begin
            cnt   <= 3'd0;
            beats <= '0;
        end else if (beat_take) begin
            cnt        <= cnt + 3'd1;
            beats[cnt] <= in_data;
        end
    end

    // Result register. It is written only in ADD, so it holds through HOLD
    // and keeps its value afterwards. clr does not wipe it; a clr landing on
    // the ADD cycle discards that add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (state == S_ADD && !clr) begin
            out_sum  <= sum_w[63:0];
            out_cout <= sum_w[64];
        end
    end

`ifdef ADD64_OVF_EN
    // Overflow when the operand signs agree but the result sign differs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (state == S_ADD && !clr) begin
            out_ovf <= (op_a[63] == op_b[63]) && (sum_w[63] != op_a[63]);
        end
    end
`endif

endmodule

// File: tb/tb_add64_operand_loader.sv
module tb_add64_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, out_ready;
    logic        in_ready, out_valid, out_cout;
    logic [15:0] in_data;
    logic [63:0] out_sum;
`ifdef ADD64_OVF_EN
    logic        out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Model of the last result register contents (sum, cout, ovf).
    logic [63:0] m_sum;
    logic        m_cout;
    logic        m_ovf;

    always #5 clk = ~clk;

    add64_operand_loader #(.BEAT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
`ifdef ADD64_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    // Reference: plain 65-bit unsigned add, and signed overflow from a
    // sign-extended 65-bit signed add falling outside the 64-bit range.
    task automatic model_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0]        u;
        logic signed [64:0] s;
        u = {1'b0, a} + {1'b0, b};
        s = $signed({a[63], a}) + $signed({b[63], b});
        m_sum  = u[63:0];
        m_cout = u[64];
        m_ovf  = (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
    endtask

    // Drive one operand pair as 8 beats, optionally with idle gaps.
    // Returns at the negedge after beat 7 was accepted (DUT in ADD).
    task automatic send_op(input logic [63:0] a, input logic [63:0] b, input bit gaps);
        logic [127:0] bits;
        bits = {b, a};
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = bits[i*16 +: 16];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 64'd0 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b sum=%h cout=%b, want 0 1 0 0",
                     out_valid, in_ready, out_sum, out_cout);
        end
`ifdef ADD64_OVF_EN
        checks++;
        if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    endtask

    // Directed vectors, back-to-back beats, immediate consume.
    task automatic test_vectors;
        logic [63:0] va [4];
        logic [63:0] vb [4];
        va[0] = 64'h0123456789ABCDEF; vb[0] = 64'hFEDCBA9876543210;
        va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'h0000000000000001;
        va[2] = 64'h7FFFFFFFFFFFFFFF; vb[2] = 64'h0000000000000001;
        va[3] = 64'h8000000000000000; vb[3] = 64'h8000000000000000;
        for (int k = 0; k < 4; k++) begin
            send_op(va[k], vb[k], 1'b0);
            model_add(va[k], vb[k]);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_add_cycle: out_valid=%b in_ready=%b want 0 0", k, out_valid, in_ready);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== m_sum || out_cout !== m_cout) begin
                errors++;
                $display("FAIL vec%0d_result: valid=%b sum=%h cout=%b want 1 %h %b",
                         k, out_valid, out_sum, out_cout, m_sum, m_cout);
            end
`ifdef ADD64_OVF_EN
            checks++;
            if (out_ovf !== m_ovf) begin errors++; $display("FAIL vec%0d_ovf: got %b want %b", k, out_ovf, m_ovf); end
`endif
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== m_sum) begin
                errors++;
                $display("FAIL vec%0d_release: valid=%b in_ready=%b sum=%h want 0 1 %h",
                         k, out_valid, in_ready, out_sum, m_sum);
            end
        end
    endtask

    // Stall in HOLD with in_valid toggling; nothing must be consumed.
    task automatic test_hold_stall;
        logic [63:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        send_op(a, b, 1'b0);
        model_add(a, b);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom);
            in_data  = 16'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== m_sum || out_cout !== m_cout) begin
                errors++;
                $display("FAIL hold_stall%0d: valid=%b in_ready=%b sum=%h want 1 0 %h", c, out_valid, in_ready, out_sum, m_sum);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        // The next operation proves no stray beat advanced the counter.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        send_op(a, b, 1'b0);
        model_add(a, b);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== m_sum || out_cout !== m_cout) begin
            errors++;
            $display("FAIL hold_next_op: valid=%b sum=%h cout=%b want 1 %h %b", out_valid, out_sum, out_cout, m_sum, m_cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Random operands, random beat gaps, random consumer delay.
    task automatic test_random;
        logic [63:0] a, b;
        int          bad;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if (k % 5 == 0) a = ~b;
            send_op(a, b, 1'b1);
            model_add(a, b);
            @(negedge clk);
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'($urandom);
                in_data  = 16'($urandom);
                @(negedge clk);
            end
            checks++;
            if (out_valid !== 1'b1 || out_sum !== m_sum || out_cout !== m_cout) begin
                errors++; bad++;
                $display("FAIL rand%0d: valid=%b sum=%h cout=%b want 1 %h %b", k, out_valid, out_sum, out_cout, m_sum, m_cout);
            end
`ifdef ADD64_OVF_EN
            checks++;
            if (out_ovf !== m_ovf) begin errors++; $display("FAIL rand%0d_ovf: got %b want %b", k, out_ovf, m_ovf); end
`endif
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0;
            if (bad > 3) break;
        end
    endtask

    // clr mid-load discards partial beats; clr in HOLD drops the result
    // but keeps out_sum.
    task automatic test_clr;
        logic [63:0] prev;
        prev = m_sum;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            @(negedge clk);
        end
        clr = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== prev) begin
            errors++;
            $display("FAIL clr_load: in_ready=%b valid=%b sum=%h want 1 0 %h", in_ready, out_valid, out_sum, prev);
        end
        send_op(64'd2, 64'd3, 1'b0);
        model_add(64'd2, 64'd3);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 64'd5 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL clr_after_sum: valid=%b sum=%h cout=%b want 1 5 0", out_valid, out_sum, out_cout);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 64'd5) begin
            errors++;
            $display("FAIL clr_hold: valid=%b in_ready=%b sum=%h want 0 1 5", out_valid, in_ready, out_sum);
        end
    endtask

    // Reset asserted during HOLD returns everything to reset values at once.
    task automatic test_reset_in_hold;
        logic [63:0] a, b;
        a = 64'h7FFFFFFFFFFFFFFF; b = 64'h7FFFFFFFFFFFFFFF;
        send_op(a, b, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold: valid=%b sum=%h cout=%b in_ready=%b want 0 0 0 1", out_valid, out_sum, out_cout, in_ready);
        end
`ifdef ADD64_OVF_EN
        checks++;
        if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_hold_ovf: got %b want 0", out_ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        send_op(a, b, 1'b0);
        model_add(a, b);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== m_sum || out_cout !== m_cout) begin
            errors++;
            $display("FAIL rst_restart: valid=%b sum=%h cout=%b want 1 %h %b", out_valid, out_sum, out_cout, m_sum, m_cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_hold_stall;
        test_random;
        test_clr;
        test_reset_in_hold;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
